// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and occupancy type for the operand stack
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int PTR_W     = $clog2(DEF_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } occ_t;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x WIDTH register array, sync write, async read
import stack_pkg::*;

module stack_ram #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO operand stack with registered read; STACK_GUARD_EN adds boundary checks
import stack_pkg::*;

module stack_unit #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tos,
    input  logic [WIDTH-1:0]         d_in,
    output logic [WIDTH-1:0]         d_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_nxt;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] waddr;
    logic [WIDTH-1:0] rdata;
    logic             we;
    logic             ld_dout;
    occ_t             occ;

    assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        occ = ST_PARTIAL;
        if (sp == '0) begin
            occ = ST_EMPTY;
        end else if (sp == SP_W'(DEPTH)) begin
            occ = ST_FULL;
        end
    end

    assign empty = (occ == ST_EMPTY);
    assign full  = (occ == ST_FULL);
    assign count = sp;

`ifdef STACK_GUARD_EN
    logic set_ovf;
    logic set_unf;
    logic ovf_q;
    logic unf_q;

    always_comb begin
        sp_nxt  = sp;
        ld_dout = 1'b0;
        we      = 1'b0;
        waddr   = sp[IDX_W-1:0];
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (push && pop) begin
            we = 1'b1;
            if (occ == ST_EMPTY) begin
                // nothing to replace, so it degrades to a plain push
                sp_nxt  = sp + SP_W'(1);
                set_unf = 1'b1;
            end else begin
                waddr   = top_idx;
                ld_dout = 1'b1;
            end
        end else if (push) begin
            if (occ == ST_FULL) begin
                set_ovf = 1'b1;
            end else begin
                we     = 1'b1;
                sp_nxt = sp + SP_W'(1);
            end
        end else if (pop || tos) begin
            if (occ == ST_EMPTY) begin
                set_unf = 1'b1;
            end else begin
                ld_dout = 1'b1;
                if (pop) begin
                    sp_nxt = sp - SP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | set_ovf;
            unf_q <= unf_q | set_unf;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    always_comb begin
        sp_nxt  = sp;
        ld_dout = 1'b0;
        we      = 1'b0;
        waddr   = sp[IDX_W-1:0];
        if (push && pop) begin
            we      = 1'b1;
            waddr   = top_idx;
            ld_dout = 1'b1;
        end else if (push) begin
            we     = 1'b1;
            sp_nxt = sp + SP_W'(1);
        end else if (pop || tos) begin
            ld_dout = 1'b1;
            if (pop) begin
                sp_nxt = sp - SP_W'(1);
            end
        end
    end

    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            d_out <= '0;
        end else begin
            sp <= sp_nxt;
            if (ld_dout) begin
                d_out <= rdata;
            end
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we && !rst),
        .waddr (waddr),
        .wdata (d_in),
        .raddr (top_idx),
        .rdata (rdata)
    );

endmodule
